// File: rtl/collision_scorer.sv
// collision_scorer: runner/obstacle collision detect, BCD score and hi score.
// Ports: clk, reset (async, active-high), start, move, step, draw[159:0] in;
//   halt, hit, game_over, flash, score_bcd[15:0], hi_bcd[15:0] out.
module collision_scorer #(
   parameter int unsigned FLASH_CYCLES = 25_000_000,
   parameter logic [15:0] SCORE_MAX    = 16'h9999
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         move,
   input  logic         step,
   input  logic [159:0] draw,
   output logic         halt,
   output logic         hit,
   output logic         game_over,
   output logic         flash,
   output logic [15:0]  score_bcd,
   output logic [15:0]  hi_bcd
);

   localparam int unsigned CNT_W =
      (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HIT  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       obs_next;
   logic [CNT_W-1:0] flash_cnt;
   logic [1:0]       h_r;
   logic             eval_en;
   logic             collide;
   logic             pass;
   logic [15:0]      hi_best;
   logic             draw_unused;

   // Per-digit increment with carry; caller guards saturation.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign h_r         = draw[159:158];
   assign draw_unused = ^draw[155:0];

   // start overrides any step; move low parks RUN without evaluating.
   assign eval_en = (state == S_RUN) && move && step && !start;
   assign collide = eval_en && (obs_next != 2'd0) && (h_r < obs_next);
   assign pass    = eval_en && (obs_next != 2'd0) && !collide;

   // Packed BCD orders the same as its binary value.
   assign hi_best = (score_bcd > hi_bcd) ? score_bcd : hi_bcd;

   assign game_over = (state == S_HIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         obs_next  <= 2'd0;
         hit       <= 1'b0;
         halt      <= 1'b0;
         score_bcd <= 16'h0000;
         hi_bcd    <= 16'h0000;
      end else begin
         hit  <= 1'b0;
         halt <= 1'b0;
         if (start) begin
            // Aborting a run still records the score before clearing it.
            if (state == S_RUN) hi_bcd <= hi_best;
            state     <= S_IDLE;
            score_bcd <= 16'h0000;
            obs_next  <= 2'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (move) state <= S_RUN;
               end
               S_RUN: begin
                  if (eval_en) begin
                     obs_next <= draw[157:156];
                     if (collide) begin
                        state  <= S_HIT;
                        hit    <= 1'b1;
                        halt   <= 1'b1;
                        hi_bcd <= hi_best;
                     end else if (pass && score_bcd != SCORE_MAX) begin
                        score_bcd <= bcd_inc(score_bcd);
                     end
                  end
               end
               S_HIT: begin
                  state <= S_HIT;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flash_cnt <= '0;
         flash     <= 1'b0;
      end else if (state == S_HIT && !start) begin
         if (flash_cnt == CNT_LAST) begin
            flash_cnt <= '0;
            flash     <= ~flash;
         end else begin
            flash_cnt <= flash_cnt + CNT_W'(1);
         end
      end else begin
         flash_cnt <= '0;
         flash     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_collision_scorer.sv
// tb_collision_scorer: random + directed stimulus against a behavioural model.
// Ports: none; drives collision_scorer with FLASH_CYCLES=4.
module tb_collision_scorer;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         move;
   logic         step;
   logic [159:0] draw;
   logic         halt;
   logic         hit;
   logic         game_over;
   logic         flash;
   logic [15:0]  score_bcd;
   logic [15:0]  hi_bcd;

   collision_scorer #(.FLASH_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .move      (move),
      .step      (step),
      .draw      (draw),
      .halt      (halt),
      .hit       (hit),
      .game_over (game_over),
      .flash     (flash),
      .score_bcd (score_bcd),
      .hi_bcd    (hi_bcd)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HIT  = 2;

   int n_checks = 0;
   int n_fail   = 0;
   int m_mode;
   int m_score;
   int m_hi;
   int m_obs;
   int m_age;
   bit m_hit;
   bit chk_en = 1'b0;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10),
              4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_score = 0;
      m_hi    = 0;
      m_obs   = 0;
      m_age   = 0;
      m_hit   = 1'b0;
   endtask

   task automatic model_step();
      int hr;
      int ho;
      m_hit = 1'b0;
      if (start) begin
         if (m_mode == M_RUN && m_score > m_hi) m_hi = m_score;
         m_mode  = M_IDLE;
         m_score = 0;
         m_obs   = 0;
      end else if (m_mode == M_IDLE) begin
         if (move) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (move && step) begin
            hr    = int'(draw[159:158]);
            ho    = m_obs;
            m_obs = int'(draw[157:156]);
            if (ho != 0) begin
               if (hr < ho) begin
                  m_mode = M_HIT;
                  m_hit  = 1'b1;
                  m_age  = 0;
                  if (m_score > m_hi) m_hi = m_score;
               end else if (m_score < 9999) begin
                  m_score++;
               end
            end
         end
      end else begin
         m_age++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_draw(input int runner, input int nxt);
      draw = {$urandom, $urandom, $urandom, $urandom, $urandom};
      draw[159:158] = 2'(runner);
      draw[157:156] = 2'(nxt);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("hit", 16'(hit), 16'(m_hit));
         check("halt", 16'(halt), 16'(m_hit));
         check("game_over", 16'(game_over), 16'(m_mode == M_HIT));
         check("flash", 16'(flash),
               (m_mode == M_HIT) ? 16'((m_age / 4) % 2) : 16'd0);
         check("score", score_bcd, to_bcd(m_score));
         check("hi", hi_bcd, to_bcd(m_hi));
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      move  = 1'b0;
      step  = 1'b0;
      draw  = '0;
      model_reset();
      tick();
      chk_en = 1'b1;
      check("rst_score", score_bcd, 16'h0000);
      check("rst_hi", hi_bcd, 16'h0000);
      check("rst_go", 16'(game_over), 16'h0000);
      tick();

      // pass scores one
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      move  = 1'b1;
      tick();
      step = 1'b1;
      set_draw(0, 2);
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      set_draw(3, 0);
      tick();
      step = 1'b0;
      check("t1_score", score_bcd, 16'h0001);
      check("t1_hit", 16'(hit), 16'h0000);

      // collision
      step = 1'b1;
      set_draw(3, 3);
      tick();
      set_draw(1, 0);
      tick();
      step = 1'b0;
      check("t2_hit", 16'(hit), 16'h0001);
      check("t2_halt", 16'(halt), 16'h0001);
      check("t2_go", 16'(game_over), 16'h0001);
      check("t2_score", score_bcd, 16'h0001);
      check("t2_hi", hi_bcd, 16'h0001);
      tick();
      check("t2_hit_pulse", 16'(hit), 16'h0000);

      // flash timing
      tick();
      tick();
      check("t5_flash3", 16'(flash), 16'h0000);
      tick();
      check("t5_flash4", 16'(flash), 16'h0001);
      repeat (3) tick();
      check("t5_flash7", 16'(flash), 16'h0001);
      tick();
      check("t5_flash8", 16'(flash), 16'h0000);
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_flash_clr", 16'(flash), 16'h0000);
      check("t5_go_clr", 16'(game_over), 16'h0000);

      // BCD carry and saturation
      move = 1'b1;
      tick();
      step = 1'b1;
      set_draw(3, 1);
      tick();
      repeat (99) tick();
      check("t3_99", score_bcd, 16'h0099);
      tick();
      check("t3_100", score_bcd, 16'h0100);
      repeat (9899) tick();
      check("t3_9999", score_bcd, 16'h9999);
      tick();
      check("t3_sat", score_bcd, 16'h9999);

      // step and start together
      set_draw(0, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      move  = 1'b0;
      check("t4_go", 16'(game_over), 16'h0000);
      check("t4_hit", 16'(hit), 16'h0000);
      check("t4_score", score_bcd, 16'h0000);
      check("t4_hi", hi_bcd, 16'h9999);
      set_draw(0, 3);
      tick();
      step = 1'b0;
      check("t4_ign_score", score_bcd, 16'h0000);
      check("t4_ign_go", 16'(game_over), 16'h0000);

      // async reset mid-run
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      move  = 1'b1;
      tick();
      step = 1'b1;
      set_draw(3, 1);
      tick();
      repeat (30) tick();
      step  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      step = 1'b1;
      tick();
      repeat (12) tick();
      step = 1'b0;
      check("t6_score", score_bcd, 16'h0012);
      check("t6_hi", hi_bcd, 16'h0030);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_score", score_bcd, 16'h0000);
      check("t6_async_hi", hi_bcd, 16'h0000);
      check("t6_async_go", 16'(game_over), 16'h0000);
      check("t6_async_flash", 16'(flash), 16'h0000);
      tick();
      reset = 1'b0;

      // random play
      repeat (4000) begin
         start = ($urandom_range(0, 49) == 0);
         move  = ($urandom_range(0, 9) != 0);
         step  = $urandom_range(0, 1) != 0;
         reset = ($urandom_range(0, 299) == 0);
         set_draw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         tick();
      end
      reset = 1'b0;
      tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
